// File: rtl/adder_chk_pkg.sv
// Shared types and helpers for the adder pipeline checker.
// Reference add and saturation limit are sized at MAX_W and truncated by users.
package adder_chk_pkg;

    typedef enum logic {
        CHECKING = 1'b0,
        HALTED   = 1'b1
    } chk_state_e;

    localparam int unsigned MAX_W = 64;

    function automatic logic [MAX_W:0] add_ref(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input logic             cin
    );
        return {1'b0, a} + {1'b0, b} + {{MAX_W{1'b0}}, cin};
    endfunction

    function automatic logic [MAX_W-1:0] sat_max(input int unsigned w);
        logic [MAX_W-1:0] m;
        m = '0;
        for (int i = 0; i < int'(MAX_W); i++) begin
            if (i < int'(w)) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/chk_delay_line.sv
// Fixed-depth valid/data shift register, no stall.
// flush_i clears every valid bit, including the one entering this cycle.
module chk_delay_line #(
    parameter int unsigned DW    = 9,
    parameter int unsigned DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o
);

    logic [DEPTH-1:0] vld_q;
    logic [DW-1:0]    dat_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) dat_q[i] <= '0;
        end else begin
            vld_q[0] <= valid_i & ~flush_i;
            dat_q[0] <= data_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                vld_q[i] <= vld_q[i-1] & ~flush_i;
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign valid_o = vld_q[DEPTH-1];
    assign data_o  = dat_q[DEPTH-1];

endmodule

// File: rtl/adder_pipe_checker.sv
// Scoreboard for a fixed-latency WIDTH-bit adder with valid qualifiers.
// Counts compares and errors, captures the first failure, optional halt.
module adder_pipe_checker
    import adder_chk_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned STOP_ON_ERR = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             out_valid,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    output logic             mismatch,
    output logic             proto_err,
    output logic             err_flag,
    output logic             halted,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [WIDTH:0]   first_exp,
    output logic [WIDTH:0]   first_got
);

    localparam int unsigned      DW      = WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

    chk_state_e       state_q, state_d;
    logic             mis_q, mis_d;
    logic             pe_q, pe_d;
    logic             flag_q, flag_d;
    logic [CNT_W-1:0] chk_q, chk_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [DW-1:0]    fexp_q, fexp_d;
    logic [DW-1:0]    fgot_q, fgot_d;

    logic          s_vld;
    logic [DW-1:0] s_exp;
    logic [DW-1:0] exp_w;
    logic [DW-1:0] got;
    logic          cmp, bad_data, bad_proto, fail;

    assign exp_w = DW'(add_ref(MAX_W'(a), MAX_W'(b), cin));

    chk_delay_line #(
        .DW    (DW),
        .DEPTH (LATENCY)
    ) u_dly (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (clear),
        .valid_i (in_valid & enable),
        .data_i  (exp_w),
        .valid_o (s_vld),
        .data_o  (s_exp)
    );

    assign got       = {cout, sum};
    assign cmp       = s_vld & out_valid;
    assign bad_data  = cmp & (got != s_exp);
    assign bad_proto = s_vld ^ out_valid;
    assign fail      = bad_data | bad_proto;

    always_comb begin
        state_d = state_q;
        mis_d   = 1'b0;
        pe_d    = 1'b0;
        flag_d  = flag_q;
        chk_d   = chk_q;
        err_d   = err_q;
        fexp_d  = fexp_q;
        fgot_d  = fgot_q;
        if (clear) begin
            state_d = CHECKING;
            flag_d  = 1'b0;
            chk_d   = '0;
            err_d   = '0;
            fexp_d  = '0;
            fgot_d  = '0;
        end else if (state_q == CHECKING) begin
            mis_d = bad_data;
            pe_d  = bad_proto;
            if (cmp && chk_q != CNT_MAX) chk_d = chk_q + 1'b1;
            if (fail) begin
                flag_d = 1'b1;
                if (err_q != CNT_MAX) err_d = err_q + 1'b1;
                // Protocol failures record 0 for whichever side is absent.
                if (!flag_q) begin
                    fexp_d = s_vld ? s_exp : '0;
                    fgot_d = out_valid ? got : '0;
                end
                if (STOP_ON_ERR != 0) state_d = HALTED;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CHECKING;
            mis_q   <= 1'b0;
            pe_q    <= 1'b0;
            flag_q  <= 1'b0;
            chk_q   <= '0;
            err_q   <= '0;
            fexp_q  <= '0;
            fgot_q  <= '0;
        end else begin
            state_q <= state_d;
            mis_q   <= mis_d;
            pe_q    <= pe_d;
            flag_q  <= flag_d;
            chk_q   <= chk_d;
            err_q   <= err_d;
            fexp_q  <= fexp_d;
            fgot_q  <= fgot_d;
        end
    end

    assign mismatch  = mis_q;
    assign proto_err = pe_q;
    assign err_flag  = flag_q;
    assign halted    = (state_q == HALTED);
    assign chk_cnt   = chk_q;
    assign err_cnt   = err_q;
    assign first_exp = fexp_q;
    assign first_got = fgot_q;

    a_mis_flag: assert property (
        @(posedge clk) disable iff (!rst_n)
        (mismatch && !clear) |=> err_flag
    );

    a_err_mono: assert property (
        @(posedge clk) disable iff (!rst_n)
        !clear |=> (err_cnt >= $past(err_cnt))
    );

endmodule

// File: tb/tb_adder_pipe_checker.sv
// Randomised and directed bench for adder_pipe_checker.
// Expected values come from plain arithmetic over the applied vectors.
module tb_adder_pipe_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] a = '0, b = '0, sum = '0;
    logic       cin = 1'b0, cout = 1'b0;
    logic       out_valid = 1'b0;

    logic        m0, pe0, ef0, h0;
    logic [15:0] chk0, err0;
    logic [8:0]  fe0, fg0;
    logic        mh, peh, efh, hh;
    logic [15:0] chkh, errh;
    logic [8:0]  feh, fgh;
    logic        ms, pes, efs, hs;
    logic [3:0]  chks, errs;
    logic [8:0]  fes, fgs;

    int checks = 0;
    int failures = 0;

    logic [7:0] va [200];
    logic [7:0] vb [200];
    logic       vc [200];
    logic       ven [200];
    logic       vout [200];
    logic       bad [200];
    logic [8:0] expv [200];
    logic [8:0] gv [200];
    bit         mis_log [300];
    bit         pe_log [300];

    always #5 clk = ~clk;

    adder_pipe_checker dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
        .in_valid(in_valid), .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .sum(sum), .cout(cout),
        .mismatch(m0), .proto_err(pe0), .err_flag(ef0), .halted(h0),
        .chk_cnt(chk0), .err_cnt(err0),
        .first_exp(fe0), .first_got(fg0)
    );

    adder_pipe_checker #(.STOP_ON_ERR(1)) dut_h (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
        .in_valid(in_valid), .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .sum(sum), .cout(cout),
        .mismatch(mh), .proto_err(peh), .err_flag(efh), .halted(hh),
        .chk_cnt(chkh), .err_cnt(errh),
        .first_exp(feh), .first_got(fgh)
    );

    adder_pipe_checker #(.CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
        .in_valid(in_valid), .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .sum(sum), .cout(cout),
        .mismatch(ms), .proto_err(pes), .err_flag(efs), .halted(hs),
        .chk_cnt(chks), .err_cnt(errs),
        .first_exp(fes), .first_got(fgs)
    );

    function automatic logic [8:0] ref_add(logic [7:0] x, logic [7:0] y, logic c);
        return 9'(x) + 9'(y) + 9'(c);
    endfunction

    task automatic set_vec(int i, logic [7:0] x, logic [7:0] y, logic c);
        va[i] = x; vb[i] = y; vc[i] = c;
        ven[i] = 1'b1; vout[i] = 1'b1; bad[i] = 1'b0;
        expv[i] = ref_add(x, y, c);
        gv[i] = expv[i];
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; out_valid = 1'b0; enable = 1'b1;
        a = '0; b = '0; cin = 1'b0; sum = '0; cout = 1'b0;
    endtask

    task automatic do_clear();
        idle_inputs();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    // Ideal-or-corrupted DUT: vector k returns gv[k] lat cycles after issue.
    task automatic run_stream(int n, int lat);
        for (int j = 0; j < n + lat + 1; j++) begin
            in_valid = (j < n);
            enable   = (j < n) ? ven[j] : 1'b1;
            a   = (j < n) ? va[j] : 8'h00;
            b   = (j < n) ? vb[j] : 8'h00;
            cin = (j < n) ? vc[j] : 1'b0;
            if (j >= lat && j - lat < n && vout[j-lat]) begin
                out_valid = 1'b1;
                {cout, sum} = gv[j-lat];
            end else begin
                out_valid = 1'b0;
                {cout, sum} = 9'h000;
            end
            @(posedge clk); #1;
            mis_log[j] = m0;
            pe_log[j]  = pe0;
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({m0, pe0, ef0, h0} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b want=0000", {m0, pe0, ef0, h0});
        end
        checks++;
        if ({chk0, err0} !== 32'h0) begin
            failures++;
            $display("FAIL reset_cnt got=%h want=0", {chk0, err0});
        end
        checks++;
        if ({fe0, fg0} !== 18'h0) begin
            failures++;
            $display("FAIL reset_capture got=%h want=0", {fe0, fg0});
        end
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({pe0, err0, hh, errh, errs} !== '0) begin
            failures++;
            $display("FAIL reset_idle got=%h want=0", {pe0, err0, hh, errh, errs});
        end
    endtask

    task automatic test_random_ideal();
        int hits;
        do_clear();
        for (int i = 0; i < 100; i++)
            set_vec(i, 8'($urandom), 8'($urandom), 1'($urandom));
        run_stream(100, 2);
        hits = 0;
        for (int j = 0; j < 103; j++) hits += int'(mis_log[j]) + int'(pe_log[j]);
        checks++;
        if (chk0 !== 16'd100) begin
            failures++;
            $display("FAIL ideal_chk got=%0d want=100", chk0);
        end
        checks++;
        if (err0 !== 16'd0 || ef0 !== 1'b0) begin
            failures++;
            $display("FAIL ideal_err got=%0d/%b want=0/0", err0, ef0);
        end
        checks++;
        if (hits != 0) begin
            failures++;
            $display("FAIL ideal_pulses got=%0d want=0", hits);
        end
    endtask

    task automatic test_random_errors();
        int nbad, first, wrong;
        do_clear();
        nbad = 0; first = -1;
        for (int i = 0; i < 40; i++) begin
            set_vec(i, 8'($urandom), 8'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0 || i == 7) begin
                bad[i] = 1'b1;
                gv[i] = expv[i] ^ 9'($urandom_range(1, 511));
                nbad++;
                if (first < 0) first = i;
            end
        end
        run_stream(40, 2);
        wrong = 0;
        for (int i = 0; i < 40; i++)
            if (mis_log[i+2] != bad[i] || pe_log[i+2]) wrong++;
        checks++;
        if (wrong != 0) begin
            failures++;
            $display("FAIL rand_pulse_align got=%0d bad cycles want=0", wrong);
        end
        checks++;
        if (chk0 !== 16'd40 || err0 !== 16'(nbad)) begin
            failures++;
            $display("FAIL rand_counts got=%0d/%0d want=40/%0d", chk0, err0, nbad);
        end
        checks++;
        if (fe0 !== expv[first] || fg0 !== gv[first] || ef0 !== 1'b1) begin
            failures++;
            $display("FAIL rand_capture got=%h/%h want=%h/%h",
                     fe0, fg0, expv[first], gv[first]);
        end
    endtask

    task automatic test_directed_mismatch();
        do_clear();
        set_vec(0, 8'hFF, 8'h01, 1'b1);
        gv[0] = 9'h000;
        run_stream(1, 2);
        checks++;
        if (mis_log[1] !== 1'b0 || mis_log[2] !== 1'b1 || mis_log[3] !== 1'b0) begin
            failures++;
            $display("FAIL dir_pulse got=%b%b%b want=010",
                     mis_log[1], mis_log[2], mis_log[3]);
        end
        checks++;
        if (err0 !== 16'd1 || chk0 !== 16'd1) begin
            failures++;
            $display("FAIL dir_counts got=%0d/%0d want=1/1", err0, chk0);
        end
        checks++;
        if (fe0 !== 9'h101 || fg0 !== 9'h000) begin
            failures++;
            $display("FAIL dir_capture got=%h/%h want=101/000", fe0, fg0);
        end
    endtask

    task automatic test_late();
        do_clear();
        set_vec(0, 8'($urandom), 8'($urandom), 1'($urandom));
        run_stream(1, 3);
        checks++;
        if (pe_log[1] !== 1'b0 || pe_log[2] !== 1'b1 || pe_log[3] !== 1'b1 || pe_log[4] !== 1'b0) begin
            failures++;
            $display("FAIL late_pulses got=%b%b%b%b want=0110",
                     pe_log[1], pe_log[2], pe_log[3], pe_log[4]);
        end
        checks++;
        if (err0 !== 16'd2 || chk0 !== 16'd0) begin
            failures++;
            $display("FAIL late_counts got=%0d/%0d want=2/0", err0, chk0);
        end
        checks++;
        if (fe0 !== expv[0] || fg0 !== 9'h000) begin
            failures++;
            $display("FAIL late_capture got=%h/%h want=%h/000", fe0, fg0, expv[0]);
        end
    endtask

    task automatic test_halt();
        do_clear();
        for (int i = 0; i < 10; i++)
            set_vec(i, 8'($urandom), 8'($urandom), 1'($urandom));
        bad[4] = 1'b1; gv[4] = expv[4] ^ 9'h001;
        bad[7] = 1'b1; gv[7] = expv[7] ^ 9'h100;
        run_stream(10, 2);
        checks++;
        if (hh !== 1'b1 || chkh !== 16'd5 || errh !== 16'd1) begin
            failures++;
            $display("FAIL halt_frozen got=%b/%0d/%0d want=1/5/1", hh, chkh, errh);
        end
        checks++;
        if (feh !== expv[4] || fgh !== gv[4]) begin
            failures++;
            $display("FAIL halt_capture got=%h/%h want=%h/%h", feh, fgh, expv[4], gv[4]);
        end
        checks++;
        if (h0 !== 1'b0 || chk0 !== 16'd10 || err0 !== 16'd2) begin
            failures++;
            $display("FAIL nohalt_counts got=%b/%0d/%0d want=0/10/2", h0, chk0, err0);
        end
        do_clear();
        checks++;
        if ({hh, efh, chkh, errh, feh, fgh} !== '0) begin
            failures++;
            $display("FAIL halt_clear got=%h want=0", {hh, efh, chkh, errh, feh, fgh});
        end
        for (int i = 0; i < 3; i++)
            set_vec(i, 8'($urandom), 8'($urandom), 1'($urandom));
        run_stream(3, 2);
        checks++;
        if (chkh !== 16'd3 || hh !== 1'b0) begin
            failures++;
            $display("FAIL halt_resume got=%0d/%b want=3/0", chkh, hh);
        end
    endtask

    task automatic test_saturation();
        do_clear();
        for (int i = 0; i < 20; i++)
            set_vec(i, 8'($urandom), 8'($urandom), 1'($urandom));
        run_stream(20, 2);
        checks++;
        if (chks !== 4'hF || errs !== 4'h0) begin
            failures++;
            $display("FAIL sat_counts got=%h/%h want=f/0", chks, errs);
        end
        checks++;
        if (chk0 !== 16'd20) begin
            failures++;
            $display("FAIL sat_wide got=%0d want=20", chk0);
        end
    endtask

    task automatic test_reset_midflight();
        logic [8:0] e0, e1;
        bit p2, p3;
        e0 = ref_add(8'h12, 8'h34, 1'b0);
        e1 = ref_add(8'hF0, 8'h20, 1'b1);
        in_valid = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
        @(posedge clk); #1;
        a = 8'hF0; b = 8'h20; cin = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        rst_n = 1'b0;
        #1;
        checks++;
        if (chk0 !== 16'd0 || chks !== 4'd0) begin
            failures++;
            $display("FAIL rst_async got=%0d/%0d want=0/0", chk0, chks);
        end
        #2;
        rst_n = 1'b1;
        out_valid = 1'b1; {cout, sum} = e0;
        @(posedge clk); #1;
        p2 = pe0;
        {cout, sum} = e1;
        @(posedge clk); #1;
        p3 = pe0;
        idle_inputs();
        @(posedge clk); #1;
        checks++;
        if (!p2 || !p3) begin
            failures++;
            $display("FAIL rst_pulses got=%b%b want=11", p2, p3);
        end
        checks++;
        if (err0 !== 16'd2 || chk0 !== 16'd0) begin
            failures++;
            $display("FAIL rst_counts got=%0d/%0d want=2/0", err0, chk0);
        end
    endtask

    task automatic test_enable();
        do_clear();
        for (int i = 0; i < 4; i++)
            set_vec(i, 8'($urandom), 8'($urandom), 1'($urandom));
        ven[2] = 1'b0; ven[3] = 1'b0;
        vout[2] = 1'b0; vout[3] = 1'b0;
        run_stream(4, 2);
        checks++;
        if (chk0 !== 16'd2 || err0 !== 16'd0) begin
            failures++;
            $display("FAIL enable_drain got=%0d/%0d want=2/0", chk0, err0);
        end
    endtask

    task automatic test_clear_priority();
        do_clear();
        in_valid = 1'b1; a = 8'h55; b = 8'hAA; cin = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;
        clear = 1'b1;
        out_valid = 1'b1; {cout, sum} = 9'h0AB;
        @(posedge clk); #1;
        clear = 1'b0;
        idle_inputs();
        checks++;
        if ({m0, pe0, ef0} !== 3'b0 || chk0 !== 16'd0 || err0 !== 16'd0) begin
            failures++;
            $display("FAIL clear_prio got=%b/%0d/%0d want=000/0/0",
                     {m0, pe0, ef0}, chk0, err0);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (err0 !== 16'd0) begin
            failures++;
            $display("FAIL clear_flush got=%0d want=0", err0);
        end
    endtask

    initial begin
        test_reset();
        test_random_ideal();
        test_random_errors();
        test_directed_mismatch();
        test_late();
        test_halt();
        test_saturation();
        test_reset_midflight();
        test_enable();
        test_clear_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adder_pipe_checker.md
Name: adder_pipe_checker

Overview:
- Synthesisable, clocked checker for a WIDTH-bit ripple or pipelined adder with a fixed LATENCY and valid qualifiers.
- Generalises the single-bit full-adder sum/carry checks to multi-bit operands, pipelined latency and valid-protocol checking.
- Adds error counting, first-failure capture and an optional halt-on-error mode.
- Bound beside the DUT in block-level benches and in the adder subsystem top; it has no influence on the DUT.

Parameters:
- WIDTH, 8, operand and sum width (>=1).
- LATENCY, 2, DUT cycles from in_valid to out_valid (>=1).
- CNT_W, 16, width of check and error counters.
- STOP_ON_ERR, 0, 1 = halt checking after the first failure.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  arms checking. Inputs sampled while enable=0 are not queued.
- clear  in  1  synchronous clear of counters, flags, capture and pipeline.
- in_valid  in  1  DUT operand valid.
- a  in  WIDTH  DUT operand a.
- b  in  WIDTH  DUT operand b.
- cin  in  1  DUT carry in.
- out_valid  in  1  DUT result valid.
- sum  in  WIDTH  DUT sum.
- cout  in  1  DUT carry out.
- mismatch  out  1  one-cycle pulse on a data miscompare.
- proto_err  out  1  one-cycle pulse on a valid misalignment.
- err_flag  out  1  sticky: any mismatch or proto_err since reset/clear.
- halted  out  1  high in state HALTED.
- chk_cnt  out  CNT_W  results compared, saturating.
- err_cnt  out  CNT_W  mismatches plus proto_errs, saturating.
- first_exp  out  WIDTH+1  {cout,sum} expected at the first failure.
- first_got  out  WIDTH+1  {cout,sum} observed at the first failure.

Behaviour:
- Reset: all outputs 0, pipeline valid bits 0, state CHECKING.
- Model:
  - exp = a + b + cin, computed at WIDTH+1 bits; MSB is the expected cout.
  - Pushed into a LATENCY-stage shift register with a valid bit: v0 = in_valid & enable.
  - The register shifts every cycle, no stall.
  - Stage LATENCY-1 is compared on the same cycle out_valid is sampled.
  - A result from in_valid at edge t is compared at edge t+LATENCY.
- Compare cycle, when stage valid & out_valid:
  - chk_cnt++.
  - If {cout,sum} != exp: mismatch=1 and err_cnt++.
- Protocol check: stage valid XOR out_valid -> proto_err=1, err_cnt++. No chk_cnt increment.
- Simultaneous events:
  - mismatch and proto_err are mutually exclusive by construction.
  - err_cnt increments by at most 1 per cycle.
- Outputs are registered: mismatch and proto_err assert the cycle after the compare edge.
- Capture:
  - On the first failure with err_flag=0, load first_exp and first_got.
  - For proto_err, load the expected value (0 if no stage valid) and the observed value (0 if out_valid=0).
  - Later failures never overwrite the capture.
- Saturation: counters stick at all-ones and never wrap.
- FSM:
  - States: CHECKING, HALTED.
  - CHECKING -> HALTED on any failure when STOP_ON_ERR=1.
  - In HALTED: counters, capture and pulses are frozen; the pipeline still shifts.
  - HALTED -> CHECKING only on clear or reset.
- clear:
  - Zeros counters, err_flag, capture and pipeline valids; state returns to CHECKING.
  - clear has priority over a same-cycle compare: that compare is discarded.
- enable deassert mid-flight: entries already queued still complete and are checked. New inputs are not queued.
- Reset mid-operation: everything flushes immediately, asynchronously. A DUT out_valid arriving after reset release with no queued entry raises proto_err.
- Optional SVA in the same file, disabled when rst_n=0:
  - mismatch |-> err_flag next cycle.
  - err_cnt is non-decreasing except on clear.

Decomposition:
- Package adder_chk_pkg holds:
  - typedef chk_state_e {CHECKING, HALTED};
  - function add_ref(a,b,cin) returning WIDTH+1 bits (parametrised via a parameterised class or a macro width);
  - constant SAT helper.
- One sub-module, chk_delay_line:
  - Parametrised WIDTH+1 data plus a valid bit, depth LATENCY.
  - Async active-low reset and synchronous flush input.

Test Plan:
- WIDTH=8, LATENCY=2, ideal DUT model: 100 random operands, continuous in_valid. -> chk_cnt=100, err_cnt=0, err_flag=0.
- DUT returns a=8'hFF, b=8'h01, cin=1 with {cout,sum}=9'h000 instead of 9'h101. -> mismatch pulse, err_cnt=1, first_exp=9'h101, first_got=9'h000.
- DUT out_valid one cycle late (latency 3). -> proto_err on the expected cycle and on the late cycle, err_cnt=2, chk_cnt=0.
- STOP_ON_ERR=1: inject an error on vector 5 of 10. -> halted=1, chk_cnt=5, err_cnt=1, frozen after. clear -> all zero, CHECKING resumes.
- CNT_W=4: 20 good vectors. -> chk_cnt=4'hF saturated, no wrap.
- rst_n low for 1 cycle with 2 entries in flight, DUT still emits 2 results. -> 2 proto_err pulses, err_cnt=2, chk_cnt=0.
